led_indicator_ctrl: RTL and testbench

//  Parametrised LED/RGB indicator controller for the vending machine front panel.

---
 rtl/led_indicator_ctrl_if.sv | 33 +++
 rtl/led_indicator_ctrl.sv | 155 +++++++++++++++
 tb/tb_led_indicator_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/led_indicator_ctrl_if.sv
// Signal bundle between the vending FSM and the front-panel LED indicator controller.
// The brightness signal exists only when LED_PWM_EN is defined.
interface led_indicator_ctrl_if #(
  parameter int NUM_LEDS = 16
`ifdef LED_PWM_EN
  , parameter int PWM_BITS = 4
`endif
);
  logic [5:0]          state;
  logic [2:0]          in_goods_high;
  logic [2:0]          in_goods_low;
  logic [1:0]          in_goods_num;
  logic                chase_dir;
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] brightness;
`endif
  logic [NUM_LEDS-1:0] led_btn;
  logic [2:0]          rgb1;
  logic [2:0]          rgb2;
  logic                tick;

`ifdef LED_PWM_EN
  modport master (output state, in_goods_high, in_goods_low, in_goods_num, chase_dir, brightness,
                  input  led_btn, rgb1, rgb2, tick);
  modport slave  (input  state, in_goods_high, in_goods_low, in_goods_num, chase_dir, brightness,
                  output led_btn, rgb1, rgb2, tick);
`else
  modport master (output state, in_goods_high, in_goods_low, in_goods_num, chase_dir,
                  input  led_btn, rgb1, rgb2, tick);
  modport slave  (input  state, in_goods_high, in_goods_low, in_goods_num, chase_dir,
                  output led_btn, rgb1, rgb2, tick);
`endif
endinterface

// File: rtl/led_indicator_ctrl.sv
// Front-panel LED/RGB indicator controller: per-state chase, selection, blink, fill, all-on and error displays.
// Optional macro LED_PWM_EN adds a brightness input and a free-running PWM gate on all LED outputs.
module led_indicator_ctrl #(
  parameter int NUM_LEDS = 16,
  parameter int STEP_MAX = 24_999_999
`ifdef LED_PWM_EN
  , parameter int PWM_BITS = 4
`endif
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  led_indicator_ctrl_if.slave bus
);
  localparam int               CNT_W     = (STEP_MAX > 0) ? $clog2(STEP_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_MAX);
  localparam logic [5:0]       ST_IDLE   = 6'h01;
  localparam logic [5:0]       ST_GOODS1 = 6'h02;
  localparam logic [5:0]       ST_GOODS2 = 6'h04;
  localparam logic [5:0]       ST_PAY    = 6'h08;
  localparam logic [5:0]       ST_CHANGE = 6'h10;
  localparam logic [5:0]       ST_TEMP   = 6'h20;

  typedef enum logic [2:0] {
    MODE_IDLE, MODE_GOODS1, MODE_GOODS2, MODE_PAY, MODE_CHANGE, MODE_TEMP, MODE_ERR
  } mode_e;

  mode_e               mode_s;
  logic [5:0]          state_r;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [NUM_LEDS-1:0] chase_r, chase_s, fill_r, fill_s, goods_s, led_s;
  logic                phase_r, phase_s;
  logic                entry_s, wrap_s, tick_s, pwm_on_s;
  logic [2:0]          rgb1_s, rgb2_s;
`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_r;
`endif

  // Decode the sampled one-hot state into a display mode; anything else is an error.
  always_comb begin
    mode_s = MODE_ERR;
    case (bus.state)
      ST_IDLE:   mode_s = MODE_IDLE;
      ST_GOODS1: mode_s = MODE_GOODS1;
      ST_GOODS2: mode_s = MODE_GOODS2;
      ST_PAY:    mode_s = MODE_PAY;
      ST_CHANGE: mode_s = MODE_CHANGE;
      ST_TEMP:   mode_s = MODE_TEMP;
      default:   mode_s = MODE_ERR;
    endcase
  end

  // Next prescaler and pattern values; a mode entry reloads and overrides a coincident tick.
  always_comb begin
    entry_s = (bus.state != state_r);
    wrap_s  = (cnt_r == STEP_LAST);
    cnt_s   = (entry_s || wrap_s) ? {CNT_W{1'b0}} : cnt_r + 1'b1;
    tick_s  = (cnt_s == STEP_LAST);
    chase_s = chase_r;
    fill_s  = fill_r;
    phase_s = phase_r;
    if (entry_s) begin
      chase_s = bus.chase_dir ? {1'b1, {(NUM_LEDS-1){1'b0}}} : {{(NUM_LEDS-1){1'b0}}, 1'b1};
      fill_s  = {NUM_LEDS{1'b0}};
      phase_s = 1'b1;
    end else if (wrap_s) begin
      case (mode_s)
        MODE_IDLE:   chase_s = bus.chase_dir ? {chase_r[0], chase_r[NUM_LEDS-1:1]}
                                             : {chase_r[NUM_LEDS-2:0], chase_r[NUM_LEDS-1]};
        MODE_CHANGE: fill_s  = {fill_r[NUM_LEDS-2:0], 1'b1};
        MODE_PAY:    phase_s = ~phase_r;
        MODE_ERR:    phase_s = ~phase_r;
        default:     phase_s = phase_r;
      endcase
    end else begin
      phase_s = phase_r;
    end
  end

  // Raw display pattern and colours for the mode, then the optional brightness gate.
  always_comb begin
    goods_s      = {NUM_LEDS{1'b0}};
    goods_s[7:0] = {bus.in_goods_num, bus.in_goods_high, bus.in_goods_low};
    led_s        = {NUM_LEDS{1'b0}};
    rgb1_s       = 3'b000;
    rgb2_s       = 3'b000;
    case (mode_s)
      MODE_IDLE:   led_s = chase_s;
      MODE_GOODS1: begin
        led_s  = goods_s;
        rgb1_s = 3'b100;
        rgb2_s = (bus.in_goods_num != 2'b00) ? 3'b010 : 3'b000;
      end
      MODE_GOODS2: begin
        led_s  = goods_s;
        rgb1_s = 3'b010;
        rgb2_s = (bus.in_goods_num != 2'b00) ? 3'b010 : 3'b000;
      end
      MODE_PAY: begin
        led_s  = {NUM_LEDS{phase_s}};
        rgb1_s = 3'b001;
        rgb2_s = {2'b00, phase_s};
      end
      MODE_CHANGE: begin
        led_s  = fill_s;
        rgb1_s = 3'b110;
      end
      MODE_TEMP: begin
        led_s  = {NUM_LEDS{1'b1}};
        rgb1_s = 3'b111;
      end
      default: rgb2_s = {phase_s, 2'b00};
    endcase
`ifdef LED_PWM_EN
    pwm_on_s = (pwm_r < bus.brightness);
`else
    pwm_on_s = 1'b1;
`endif
  end

  // State, prescaler, pattern and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      chase_r     <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
      fill_r      <= {NUM_LEDS{1'b0}};
      phase_r     <= 1'b1;
      bus.led_btn <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
      bus.rgb1    <= 3'b000;
      bus.rgb2    <= 3'b000;
      bus.tick    <= 1'b0;
    end else begin
      state_r     <= bus.state;
      cnt_r       <= cnt_s;
      chase_r     <= chase_s;
      fill_r      <= fill_s;
      phase_r     <= phase_s;
      bus.led_btn <= led_s & {NUM_LEDS{pwm_on_s}};
      bus.rgb1    <= rgb1_s & {3{pwm_on_s}};
      bus.rgb2    <= rgb2_s & {3{pwm_on_s}};
      bus.tick    <= tick_s;
    end
  end

`ifdef LED_PWM_EN
  // Free-running brightness counter; unaffected by mode entry.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pwm_r <= {PWM_BITS{1'b0}};
    end else begin
      pwm_r <= pwm_r + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_led_indicator_ctrl.sv
// Self-checking bench for led_indicator_ctrl (NUM_LEDS=16, STEP_MAX=3): per-cycle model compare plus directed literals.
module tb_led_indicator_ctrl;
  localparam int N  = 16;
  localparam int SM = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

`ifdef LED_PWM_EN
  led_indicator_ctrl_if #(.NUM_LEDS(N), .PWM_BITS(4)) bus ();
  led_indicator_ctrl #(.NUM_LEDS(N), .STEP_MAX(SM), .PWM_BITS(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus.slave));
`else
  led_indicator_ctrl_if #(.NUM_LEDS(N)) bus ();
  led_indicator_ctrl #(.NUM_LEDS(N), .STEP_MAX(SM)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus.slave));
`endif

  // Model state: prescaler count, chase position, fill length, blink phase.
  int         m_cnt, m_pos, m_fill, m_pwm;
  bit         m_phase;
  logic [5:0] m_sq;
  logic [N-1:0] e_led;
  logic [2:0]   e_rgb1, e_rgb2;
  logic         e_tick;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    int ncnt, pos, fill;
    bit ph, entry, on;
    logic [N-1:0] led;
    logic [2:0] c1, c2;
    if (!rst_n) begin
      m_cnt <= 0; m_pos <= 0; m_fill <= 0; m_phase <= 1'b1; m_sq <= 6'h01; m_pwm <= 0;
      e_led <= 16'h0001; e_rgb1 <= 3'b000; e_rgb2 <= 3'b000; e_tick <= 1'b0;
    end else begin
      entry = (bus.state != m_sq);
      pos = m_pos; fill = m_fill; ph = m_phase; ncnt = m_cnt + 1;
      if (entry) begin
        ncnt = 0; pos = bus.chase_dir ? N - 1 : 0; fill = 0; ph = 1'b1;
      end else if (m_cnt == SM) begin
        ncnt = 0;
        case (bus.state)
          6'h01:   pos = bus.chase_dir ? (pos + N - 1) % N : (pos + 1) % N;
          6'h10:   fill = (fill < N) ? fill + 1 : N;
          6'h08:   ph = !ph;
          default: if ($countones(bus.state) != 1) ph = !ph;
        endcase
      end
      led = '0; c1 = 3'b000; c2 = 3'b000;
      case (bus.state)
        6'h01: led[pos] = 1'b1;
        6'h02, 6'h04: begin
          led[7:0] = {bus.in_goods_num, bus.in_goods_high, bus.in_goods_low};
          c1 = (bus.state == 6'h02) ? 3'b100 : 3'b010;
          c2 = (bus.in_goods_num != 2'b00) ? 3'b010 : 3'b000;
        end
        6'h08: begin led = ph ? '1 : '0; c1 = 3'b001; c2 = ph ? 3'b001 : 3'b000; end
        6'h10: begin for (int i = 0; i < N; i++) led[i] = (i < fill); c1 = 3'b110; end
        6'h20: begin led = '1; c1 = 3'b111; end
        default: c2 = ph ? 3'b100 : 3'b000;
      endcase
`ifdef LED_PWM_EN
      on = (m_pwm < int'(bus.brightness));
      m_pwm <= (m_pwm + 1) % 16;
`else
      on = 1'b1;
`endif
      if (!on) begin led = '0; c1 = 3'b000; c2 = 3'b000; end
      m_cnt <= ncnt; m_pos <= pos; m_fill <= fill; m_phase <= ph; m_sq <= bus.state;
      e_led <= led; e_rgb1 <= c1; e_rgb2 <= c2; e_tick <= (ncnt == SM);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_led", bus.led_btn, e_led);
      cmp("model_rgb1", bus.rgb1, e_rgb1);
      cmp("model_rgb2", bus.rgb2, e_rgb2);
      cmp("model_tick", bus.tick, e_tick);
    end
  end

  initial begin
    bus.state = 6'h01; bus.chase_dir = 1'b0;
    bus.in_goods_high = 3'b000; bus.in_goods_low = 3'b000; bus.in_goods_num = 2'b00;
`ifdef LED_PWM_EN
    bus.brightness = 4'd4;
`endif
    @(negedge clk); chk_en = 1'b1;
    clk_n(1);
`ifdef LED_PWM_EN
    rst_n = 1'b1;
    bus.state = 6'h20;
    clk_n(4);
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 16; i++) begin clk_n(1); if (bus.led_btn[0]) hi++; end
      cmp("pwm_duty4", hi, 4);
      bus.brightness = 4'd0;
      clk_n(2);
      hi = 0;
      for (int i = 0; i < 16; i++) begin clk_n(1); if (bus.led_btn != '0) hi++; end
      cmp("pwm_duty0", hi, 0);
    end
`else
    cmp("rst_led", bus.led_btn, 16'h0001);
    cmp("rst_tick", bus.tick, 1'b0);
    cmp("rst_rgb", {bus.rgb1, bus.rgb2}, 6'b000000);
    rst_n = 1'b1;
    clk_n(3); cmp("t1_tick", bus.tick, 1'b1); cmp("t1_led", bus.led_btn, 16'h0001);
    clk_n(1); cmp("t1_led2", bus.led_btn, 16'h0002); cmp("t1_tick0", bus.tick, 1'b0);
    clk_n(60); cmp("t1_wrap", bus.led_btn, 16'h0001);
    bus.chase_dir = 1'b1;
    clk_n(4); cmp("t2_msb", bus.led_btn, 16'h8000);
    clk_n(4); cmp("t2_next", bus.led_btn, 16'h4000);
    bus.state = 6'h02; bus.in_goods_num = 2'b10; bus.in_goods_high = 3'b001; bus.in_goods_low = 3'b100;
    clk_n(1); cmp("t3_led", bus.led_btn, 16'h008C);
    cmp("t3_rgb1", bus.rgb1, 3'b100); cmp("t3_rgb2", bus.rgb2, 3'b010);
    bus.state = 6'h04; bus.in_goods_num = 2'b00;
    clk_n(1); cmp("t3_led2", bus.led_btn, 16'h000C);
    cmp("t3_rgb1b", bus.rgb1, 3'b010); cmp("t3_rgb2b", bus.rgb2, 3'b000);
    bus.state = 6'h10;
    clk_n(1); cmp("t4_led0", bus.led_btn, 16'h0000); cmp("t4_rgb1", bus.rgb1, 3'b110);
    clk_n(4); cmp("t4_led1", bus.led_btn, 16'h0001);
    clk_n(4); cmp("t4_led2", bus.led_btn, 16'h0003);
    clk_n(56); cmp("t4_full", bus.led_btn, 16'hFFFF);
    clk_n(8); cmp("t4_hold", bus.led_btn, 16'hFFFF);
    bus.state = 6'b000011;
    clk_n(1); cmp("t5_led", bus.led_btn, 16'h0000);
    cmp("t5_rgb1", bus.rgb1, 3'b000); cmp("t5_rgb2a", bus.rgb2, 3'b100);
    clk_n(4); cmp("t5_rgb2b", bus.rgb2, 3'b000);
    clk_n(4); cmp("t5_rgb2c", bus.rgb2, 3'b100);
    bus.state = 6'h08;
    clk_n(1); cmp("t5_pay", bus.led_btn, 16'hFFFF); cmp("t5_payrgb2", bus.rgb2, 3'b001);
    clk_n(2); cmp("t5_tick0", bus.tick, 1'b0);
    clk_n(1); cmp("t5_tick1", bus.tick, 1'b1);
    clk_n(1); cmp("t5_off", bus.led_btn, 16'h0000); cmp("t5_offrgb2", bus.rgb2, 3'b000);
    bus.state = 6'h20;
    clk_n(1); cmp("temp_led", bus.led_btn, 16'hFFFF); cmp("temp_rgb1", bus.rgb1, 3'b111);
    bus.state = 6'h01; bus.chase_dir = 1'b0;
    clk_n(1); cmp("idle_entry", bus.led_btn, 16'h0001);
    clk_n(3); cmp("beat_tick", bus.tick, 1'b1);
    bus.state = 6'h10;
    clk_n(1); cmp("beat_reload", bus.led_btn, 16'h0000);
    clk_n(3); cmp("beat_tick2", bus.tick, 1'b1);
    clk_n(1); cmp("beat_fill1", bus.led_btn, 16'h0001);
    bus.state = 6'h01; bus.chase_dir = 1'b1;
    clk_n(1); cmp("entry_dir1", bus.led_btn, 16'h8000);
    bus.chase_dir = 1'b0;
    clk_n(4); cmp("dir_nowrap", bus.led_btn, 16'h0001);
    clk_n(24); cmp("t6_pre", bus.led_btn, 16'h0040);
    rst_n = 1'b0;
    clk_n(1); cmp("t6_led", bus.led_btn, 16'h0001); cmp("t6_tick", bus.tick, 1'b0);
    cmp("t6_rgb", {bus.rgb1, bus.rgb2}, 6'b000000);
    rst_n = 1'b1;
    clk_n(8); cmp("t6_after", bus.led_btn, 16'h0004);
`endif
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
